// File: rtl/btn_event_nexys3_pkg.sv
// btn_event_nexys3_pkg: shared button FSM encodings and elaboration-time width helpers.
package btn_event_nexys3_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_HOLD   = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // An index bus needs at least one bit even for a single button.
    function automatic int code_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_nexys3_unit.sv
// btn_event_unit: per-button synchroniser, IDLE/HOLD/REPEAT FSM and millisecond hold counter.
module btn_event_unit
    import btn_event_nexys3_pkg::*;
#(
    parameter int HOLD_DELAY_MS = 500,
    parameter int REPEAT_MS     = 100
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic ms_tick,
    output logic press,
    output logic rpt,
    output logic rel,
    output logic held
);

    localparam int CNT_W = clog2(max_int(HOLD_DELAY_MS, REPEAT_MS) + 1);

    logic             s1, s2;
    btn_state_t       st;
    logic [CNT_W-1:0] cnt, cnt_nxt, lim;

    assign held    = s2;
    assign cnt_nxt = cnt + 1'b1;
    assign lim     = (st == BTN_HOLD) ? CNT_W'(HOLD_DELAY_MS) : CNT_W'(REPEAT_MS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            st    <= BTN_IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rpt   <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            rpt   <= 1'b0;
            rel   <= 1'b0;
            case (st)
                BTN_IDLE: begin
                    if (s2) begin
                        press <= 1'b1;
                        cnt   <= '0;
                        st    <= BTN_HOLD;
                    end
                end
                default: begin
                    // Release wins over a repeat falling due in the same cycle.
                    if (!s2) begin
                        rel <= 1'b1;
                        st  <= BTN_IDLE;
                    end else if (ms_tick) begin
                        if (cnt_nxt == lim) begin
                            press <= 1'b1;
                            rpt   <= 1'b1;
                            cnt   <= '0;
                            st    <= BTN_REPEAT;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_nexys3.sv
// btn_event_nexys3: button levels to press/release/repeat pulses plus a queued valid/ack event stream.
module btn_event_nexys3
    import btn_event_nexys3_pkg::*;
#(
    parameter  int CLK_FREQ      = 10,
    parameter  int BTN_NUM       = 4,
    parameter  int HOLD_DELAY_MS = 500,
    parameter  int REPEAT_MS     = 100,
    localparam int CW            = code_width(BTN_NUM)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BTN_NUM-1:0] btn_i,
    output logic [BTN_NUM-1:0] press_o,
    output logic [BTN_NUM-1:0] release_o,
    output logic [BTN_NUM-1:0] held_o,
    output logic               evt_valid,
    output logic [CW-1:0]      evt_code,
    output logic               evt_repeat,
    input  logic               evt_ack,
    output logic               evt_lost
);

    localparam int TICKS = CLK_FREQ * 1000;
    localparam int PW    = clog2(TICKS);

    logic [PW-1:0]      pre;
    logic               ms_tick;
    logic [BTN_NUM-1:0] rpt, pend, prep, clr;
    logic [CW-1:0]      sel;
    logic               any_pend, load;

    assign ms_tick = pre == PW'(TICKS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre <= '0;
        else        pre <= ms_tick ? '0 : pre + 1'b1;
    end

    for (genvar g = 0; g < BTN_NUM; g++) begin : g_unit
        btn_event_unit #(
            .HOLD_DELAY_MS(HOLD_DELAY_MS),
            .REPEAT_MS    (REPEAT_MS)
        ) u_unit (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn_i[g]),
            .ms_tick(ms_tick),
            .press  (press_o[g]),
            .rpt    (rpt[g]),
            .rel    (release_o[g]),
            .held   (held_o[g])
        );
    end

    // Lowest-index pending button is presented first.
    always_comb begin
        sel = '0;
        for (int i = BTN_NUM - 1; i >= 0; i--)
            if (pend[i]) sel = CW'(i);
    end

    assign any_pend = |pend;
    assign load     = (!evt_valid || evt_ack) && any_pend;
    assign clr      = load ? BTN_NUM'(1) << sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            prep       <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_repeat <= 1'b0;
            evt_lost   <= 1'b0;
        end else begin
            // A new pulse on a slot being drained this cycle refills it rather than being lost.
            pend     <= (pend & ~clr) | press_o;
            prep     <= (press_o & rpt) | (prep & ~press_o);
            evt_lost <= |(press_o & pend & ~clr);
            if (!evt_valid || evt_ack) evt_valid <= any_pend;
            if (load) begin
                evt_code   <= sel;
                evt_repeat <= prep[sel];
            end
        end
    end

endmodule

// File: tb/tb_btn_event_nexys3.sv
// tb_btn_event_nexys3: scoreboard bench; a ms-arithmetic reference model predicts pulses and events.
module tb_btn_event_nexys3;

    localparam int N    = 4;
    localparam int HOLD = 3;
    localparam int REP  = 2;
    localparam int TPM  = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_i = '0;
    logic         evt_ack = 1'b0;
    logic [N-1:0] press_o, release_o, held_o;
    logic         evt_valid, evt_repeat, evt_lost;
    logic [1:0]   evt_code;

    always #5 clk = ~clk;

    btn_event_nexys3 #(
        .CLK_FREQ(1), .BTN_NUM(N), .HOLD_DELAY_MS(HOLD), .REPEAT_MS(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_i), .press_o(press_o), .release_o(release_o),
        .held_o(held_o), .evt_valid(evt_valid), .evt_code(evt_code), .evt_repeat(evt_repeat),
        .evt_ack(evt_ack), .evt_lost(evt_lost)
    );

    typedef struct {int e; logic [N-1:0] v;} pv_t;
    typedef struct {int e; logic [1:0] code; logic rep;} ev_t;

    pv_t pressq[$], relq[$];
    ev_t evq[$];
    int  lostq[$];

    int checks = 0, passes = 0;
    int ack_mode = 0;
    int ev_cnt = 0, rep_cnt = 0, lost_cnt = 0;

    int           ecnt;
    logic [N-1:0] bh[$];
    logic [N-1:0] slot, srep, pp, pr, held_exp;
    logic         m_valid;
    int           pstart[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_press"}, press_o, 0);
        chk({tag, "_release"}, release_o, 0);
        chk({tag, "_held"}, held_o, 0);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_code"}, evt_code, 0);
        chk({tag, "_repeat"}, evt_repeat, 0);
        chk({tag, "_lost"}, evt_lost, 0);
    endtask

    task automatic check_drain();
        chk("press_left", pressq.size(), 0);
        chk("release_left", relq.size(), 0);
        chk("event_left", evq.size(), 0);
        chk("lost_left", lostq.size(), 0);
    endtask

    task automatic model_reset();
        ecnt = 0;
        bh.delete();
        slot = '0; srep = '0; pp = '0; pr = '0; held_exp = '0;
        m_valid = 1'b0;
        pressq.delete(); relq.delete(); evq.delete(); lostq.delete();
    endtask

    // Reference: sync = input two edges late; ms boundaries at every 1000th edge after reset;
    // a held button repeats on the HOLD-th boundary after its press, then every REP boundaries.
    task automatic model_step();
        logic [N-1:0] cur, prv, pv, rv, relv;
        logic         lostv, found;
        int           n;
        ecnt++;
        if (!m_valid || evt_ack) begin
            found = 1'b0;
            for (int i = 0; i < N; i++)
                if (!found && slot[i]) begin
                    found = 1'b1;
                    slot[i] = 1'b0;
                    evq.push_back('{ecnt, 2'(i), srep[i]});
                end
            m_valid = found;
        end
        lostv = 1'b0;
        for (int i = 0; i < N; i++)
            if (pp[i]) begin
                if (slot[i]) lostv = 1'b1;
                else begin
                    slot[i] = 1'b1;
                    srep[i] = pr[i];
                end
            end
        if (lostv) lostq.push_back(ecnt);
        bh.push_front(btn_i);
        if (bh.size() > 4) void'(bh.pop_back());
        cur      = (bh.size() > 2) ? bh[2] : '0;
        prv      = (bh.size() > 3) ? bh[3] : '0;
        held_exp = (bh.size() > 1) ? bh[1] : '0;
        pv = '0; rv = '0; relv = '0;
        for (int i = 0; i < N; i++) begin
            if (cur[i] && !prv[i]) begin
                pv[i] = 1'b1;
                pstart[i] = ecnt;
            end else if (cur[i] && ecnt % TPM == 0) begin
                n = ecnt / TPM - pstart[i] / TPM;
                if (n >= HOLD && (n - HOLD) % REP == 0) begin
                    pv[i] = 1'b1;
                    rv[i] = 1'b1;
                end
            end
            if (!cur[i] && prv[i]) relv[i] = 1'b1;
        end
        if (pv != 0) pressq.push_back('{ecnt, pv});
        if (relv != 0) relq.push_back('{ecnt, relv});
        pp = pv;
        pr = rv;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            evt_ack = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT shows a pulse or presents a new event.
    initial begin
        logic pval;
        pv_t  p;
        ev_t  ev;
        int   le;
        pval = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                pval = 1'b0;
                continue;
            end
            if (evt_valid && (!pval || evt_ack)) begin
                ev_cnt++;
                rep_cnt += int'(evt_repeat);
                if (evq.size() == 0) begin
                    checks++;
                    $display("FAIL evt_extra: code=%0d repeat=%0d presented at edge %0d, none required", evt_code, evt_repeat, ecnt);
                end else begin
                    ev = evq.pop_front();
                    chk("evt_edge", ecnt, ev.e);
                    chk("evt_code", evt_code, ev.code);
                    chk("evt_repeat", evt_repeat, ev.rep);
                end
            end
            if (press_o != 0) begin
                if (pressq.size() == 0) begin
                    checks++;
                    $display("FAIL press_extra: press_o=%0h at edge %0d, none required", press_o, ecnt);
                end else begin
                    p = pressq.pop_front();
                    chk("press_edge", ecnt, p.e);
                    chk("press_vec", press_o, p.v);
                end
            end
            if (release_o != 0) begin
                if (relq.size() == 0) begin
                    checks++;
                    $display("FAIL release_extra: release_o=%0h at edge %0d, none required", release_o, ecnt);
                end else begin
                    p = relq.pop_front();
                    chk("release_edge", ecnt, p.e);
                    chk("release_vec", release_o, p.v);
                end
            end
            if (evt_lost) begin
                lost_cnt++;
                if (lostq.size() == 0) begin
                    checks++;
                    $display("FAIL lost_extra: evt_lost at edge %0d, none required", ecnt);
                end else begin
                    le = lostq.pop_front();
                    chk("lost_edge", ecnt, le);
                end
            end
            chk("held", held_o, held_exp);
            pval = evt_valid;
        end
    end

    task automatic ack_pulse();
        ack_mode = 1;
        @(negedge clk);
        ack_mode = 0;
    endtask

    task automatic press_edge3(input int b, input string tag);
        btn_i[b] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk({tag, "_early"}, press_o[b], 0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_edge3"}, press_o[b], 1);
        @(posedge clk);
        #1;
        chk({tag, "_once"}, press_o[b], 0);
        @(negedge clk);
    endtask

    initial begin
        int e0, r0, l0, w;
        rst_n = 1'b0;
        btn_i = N'($urandom);
        repeat (3) @(negedge clk);
        btn_i = N'($urandom);
        #1;
        chk_zero("t1_in_reset");
        @(negedge clk);
        btn_i = '0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_zero("t1_after_reset");

        ack_mode = 0;
        press_edge3(0, "t2_press");
        repeat (46) @(negedge clk);
        btn_i[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_valid", evt_valid, 1);
        chk("t2_code", evt_code, 0);
        chk("t2_repeat", evt_repeat, 0);
        ack_pulse();
        chk("t2_valid_after_ack", evt_valid, 0);

        e0 = ev_cnt; r0 = rep_cnt; l0 = lost_cnt;
        ack_mode = 1;
        btn_i[2] = 1'b1;
        repeat (10000) @(negedge clk);
        btn_i[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("t3_events", ev_cnt - e0, 5);
        chk("t3_repeats", rep_cnt - r0, 4);
        chk("t3_lost", lost_cnt - l0, 0);

        ack_mode = 0;
        @(negedge clk);
        btn_i[1] = 1'b1;
        btn_i[3] = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_valid", evt_valid, 1);
        chk("t4_code_first", evt_code, 1);
        ack_pulse();
        chk("t4_valid_kept", evt_valid, 1);
        chk("t4_code_second", evt_code, 3);
        ack_pulse();
        chk("t4_valid_drained", evt_valid, 0);
        btn_i[1] = 1'b0;
        btn_i[3] = 1'b0;
        repeat (10) @(negedge clk);

        l0 = lost_cnt;
        repeat (3) begin
            btn_i[0] = 1'b1;
            repeat (10) @(negedge clk);
            btn_i[0] = 1'b0;
            repeat (10) @(negedge clk);
        end
        chk("t5_lost", lost_cnt - l0, 1);
        chk("t5_valid", evt_valid, 1);
        chk("t5_code", evt_code, 0);
        ack_pulse();
        chk("t5_valid_second", evt_valid, 1);
        ack_pulse();
        chk("t5_valid_drained", evt_valid, 0);

        ack_mode = 1;
        btn_i[2] = 1'b1;
        repeat (4500 + $urandom_range(0, 999)) @(negedge clk);
        check_drain();
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        chk_zero("t6_reset_now");
        repeat (5) @(posedge clk);
        #1;
        chk_zero("t6_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        press_edge3(2, "t6_press");
        repeat (4000) @(negedge clk);
        btn_i[2] = 1'b0;
        repeat (20) @(negedge clk);

        ack_mode = 2;
        repeat (120) begin
            btn_i = btn_i ^ N'(1 << $urandom_range(0, N - 1));
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 4000) : $urandom_range(1, 150);
            repeat (w) @(negedge clk);
        end
        btn_i = '0;
        ack_mode = 1;
        repeat (50) @(negedge clk);
        check_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
